alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
- Next-generation ALU for the CPU datapath, parametrised in data width.
- Keeps the existing ALUOp encodings and adds arithmetic shift, unsigned compare, iterative unsigned multiply/divide with HI/LO registers, and HI/LO reads.
- Results are registered behind a valid/ready handshake on both sides, so the control unit can stall on multi-cycle operations.

Parameters:
- DATA_W, 32, operand/result width in bits (must be at least 4).
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  4  operation code.
- src1  in  DATA_W  operand A.
- src2  in  DATA_W  operand B.
- shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  alu_result, zero, hi and lo are valid.
- out_ready  in  1  consumer takes the result this cycle.
- alu_result  out  DATA_W  registered result.
- zero  out  1  registered (alu_result == 0).
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- busy  out  1  high while in CALC.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^DATA_W); 0011 XOR; 0110 SUB (wraps); 1100 NOR.
  - 0100 SLL src2<<shamt; 0101 SRL src2>>shamt (logical); 1000 SRA src2>>>shamt (sign fill).
  - 0111 SLT: signed src1<src2 gives 1, else 0. 1001 SLTU: the same compare, unsigned.
  - 1010 MULTU (multi-cycle); 1011 DIVU (multi-cycle).
  - 1101 MFHI: result = hi. 1110 MFLO: result = lo.
  - 1111: result 0, no other effect.
- Accept rule: an operation is accepted on a rising edge with in_valid && in_ready. Operands are latched at acceptance; later input changes are ignored.
- FSM states: IDLE, CALC, DONE.
  - IDLE, single-cycle op accepted: compute, register the result, go to DONE. out_valid is high after that edge (latency 1).
  - IDLE, MULTU/DIVU accepted: go to CALC, counter cleared to 0.
  - CALC: one radix-2 iteration per cycle. After iteration DATA_W-1, go to DONE. out_valid rises DATA_W edges after the accept edge.
  - DONE, out_ready=0: hold. alu_result, zero, hi, lo and out_valid stay stable.
  - DONE, out_ready=1, no new accept: go to IDLE, out_valid drops.
  - DONE, out_ready=1, new accept: pass-through. in_ready is high in DONE when out_ready=1, so a new op is accepted on the same edge. Back-to-back single-cycle ops sustain one per cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is always 0 in CALC.
- MULTU: 2*DATA_W-bit unsigned product, shift-add. {hi,lo} = product; alu_result = low half.
- DIVU: restoring division. lo = quotient, hi = remainder, alu_result = quotient.
- DIVU with src2==0: same latency; lo = all ones, hi = src1, alu_result = all ones.
- hi/lo change only at the DONE transition of MULTU/DIVU. MFHI/MFLO read the values committed before acceptance.
- An op accepted on the same edge a MULTU/DIVU result is consumed sees the new hi/lo.
- alu_op and operands are don't-care while in_valid=0.
- Reset (async, any state including mid-CALC):
  - state to IDLE; in-flight op discarded.
  - out_valid=0, alu_result=0, zero=1, hi=0, lo=0, busy=0.
  - in_ready=1 while reset is deasserted in IDLE.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), registered with alu_result.
  - ovf=1 on signed two's-complement overflow of ADD or SUB; 0 for all other ops.
  - ovf resets to 0 and holds with the result.
  - ADD/SUB results still wrap.
- Undefined: no ovf port and no overflow logic.

Test Plan:
- Reset then ADD: release rst; accept ADD src1=7 src2=9 -> next cycle out_valid=1, alu_result=16, zero=0.
- Back-to-back stream, out_ready tied 1: SUB 5-5, then SRA of 0x80000000 by 4, then SLTU 1 vs 0xFFFFFFFF -> consecutive results 0 (zero=1), 0xF8000000, 1. in_ready stays high.
- MULTU: 0xFFFFFFFF x 2 -> out_valid exactly 32 cycles after accept, hi=1, lo=0xFFFFFFFE. Then MFHI returns 1 and MFLO returns 0xFFFFFFFE.
- DIVU: 100/7 -> lo=14, hi=2. Then DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- Backpressure: out_ready=0 for 5 cycles after AND 0xF0F0 & 0xFF00 -> result 0xF000 held stable, in_ready=0. Then out_ready=1 for 1 cycle -> out_valid drops.
- Reset mid-MULTU: assert rst at iteration 10 -> outputs immediately at reset values. After release, hi=lo=0 and a new ADD works normally.
- With ALU_OVF_EN defined: ADD 0x7FFFFFFF+1 -> ovf=1, alu_result=0x80000000.

Source files
------------

// File: rtl/alu_muldiv.sv
// ALU with registered valid/ready result, iterative unsigned MULTU/DIVU and HI/LO registers.
// Define ALU_OVF_EN to add the registered signed-overflow flag output ovf for ADD/SUB.
//
// state  | meaning
// IDLE   | no result held, ready for an operation
// CALC   | one radix-2 multiply/divide iteration per cycle
// DONE   | result held until out_ready
module alu_muldiv #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  src1,
  input  logic [DATA_W-1:0]  src2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_result,
  output logic               zero,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
`ifdef ALU_OVF_EN
  output logic               ovf,
`endif
  output logic               busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MULU = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_MFLO = 4'b1110;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q, state_nx;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                is_div_q;
  logic [DATA_W-1:0]   m_q, p_hi_q, p_lo_q;
  logic [DATA_W-1:0]   result_q, hi_q, lo_q;
  logic                zero_q;

  logic                accept, is_long;
  logic [DATA_W-1:0]   sum, diff, op_res;
  logic [DATA_W:0]     mul_sum, div_trial;
  logic                div_ge;
  logic [DATA_W-1:0]   p_hi_nx, p_lo_nx;

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept     = in_valid && in_ready;
  assign is_long    = (alu_op == OP_MULU) || (alu_op == OP_DIVU);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_CALC);
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

  assign sum  = src1 + src2;
  assign diff = src1 - src2;

  always_comb begin
    op_res = '0;
    case (alu_op)
      OP_AND:  op_res = src1 & src2;
      OP_OR:   op_res = src1 | src2;
      OP_ADD:  op_res = sum;
      OP_XOR:  op_res = src1 ^ src2;
      OP_SUB:  op_res = diff;
      OP_NOR:  op_res = ~(src1 | src2);
      OP_SLL:  op_res = src2 << shamt;
      OP_SRL:  op_res = src2 >> shamt;
      OP_SRA:  op_res = $unsigned($signed(src2) >>> shamt);
      OP_SLT:  op_res = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: op_res = {{(DATA_W-1){1'b0}}, (src1 < src2)};
      OP_MFHI: op_res = hi_q;
      OP_MFLO: op_res = lo_q;
      default: op_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_nx;
  assign ovf = ovf_q;
  always_comb begin
    ovf_nx = 1'b0;
    if (alu_op == OP_ADD)
      ovf_nx = (src1[DATA_W-1] == src2[DATA_W-1]) && (sum[DATA_W-1] != src1[DATA_W-1]);
    else if (alu_op == OP_SUB)
      ovf_nx = (src1[DATA_W-1] != src2[DATA_W-1]) && (diff[DATA_W-1] != src1[DATA_W-1]);
  end
`endif

  // p_hi/p_lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
  // A zero divisor never borrows, so the quotient fills with ones and the dividend
  // shifts whole into the remainder, giving the required divide-by-zero result.
  always_comb begin
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : '0);
    div_trial = {p_hi_q, p_lo_q[DATA_W-1]};
    div_ge    = div_trial >= {1'b0, m_q};
    if (is_div_q) begin
      if (div_ge) p_hi_nx = DATA_W'(div_trial - {1'b0, m_q});
      else        p_hi_nx = {p_hi_q[DATA_W-2:0], p_lo_q[DATA_W-1]};
      p_lo_nx = {p_lo_q[DATA_W-2:0], div_ge};
    end else begin
      p_hi_nx = mul_sum[DATA_W:1];
      p_lo_nx = {mul_sum[0], p_lo_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_nx = is_long ? S_CALC : S_DONE;
      S_CALC: if (cnt_q == CNT_LAST) state_nx = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) state_nx = is_long ? S_CALC : S_DONE;
          else          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      m_q      <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      if (is_long) begin
        is_div_q <= (alu_op == OP_DIVU);
        m_q      <= (alu_op == OP_DIVU) ? src2 : src1;
        p_lo_q   <= (alu_op == OP_DIVU) ? src1 : src2;
        p_hi_q   <= '0;
        cnt_q    <= '0;
      end else begin
        result_q <= op_res;
        zero_q   <= (op_res == '0);
`ifdef ALU_OVF_EN
        ovf_q    <= ovf_nx;
`endif
      end
    end else if (state_q == S_CALC) begin
      p_hi_q <= p_hi_nx;
      p_lo_q <= p_lo_nx;
      cnt_q  <= cnt_q + SHAMT_W'(1);
      if (cnt_q == CNT_LAST) begin
        hi_q     <= p_hi_nx;
        lo_q     <= p_lo_nx;
        result_q <= p_lo_nx;
        zero_q   <= (p_lo_nx == '0);
`ifdef ALU_OVF_EN
        ovf_q    <= 1'b0;
`endif
      end
    end
  end

endmodule
